// File: rtl/intctrl2.sv
// intctrl2: pi1-bus interrupt controller routing level requests from
// INTSRCCOUNT device sources to one of INTDSTCOUNT cores, with a
// per-source enable mask, a pending-status view, a programmable destination
// range, round-robin or fixed-priority source arbitration, and IPIs.
//
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset
//   pi1_op_i           00 nop, 01 write, 10 read, 11 read-write
//   pi1_addr_i         word offset (bits [1:0] decoded)
//   pi1_data_i/_o      write data / registered read data
//   pi1_sel_i          byte selects (ignored)
//   pi1_rdy_o          always ready
//   pi1_mapsz_o        mapping size, 4 words
//   intrqstdst_o       interrupt request per destination
//   intrdydst_i        destination can accept an interrupt
//   intbestdst_i       destination is a preferred target
//   intrqstsrc_i       level request per source
//   intrdysrc_o        low while that source's request is being delivered
module intctrl2 #(
  parameter int INTSRCCOUNT = 2,
  parameter int INTDSTCOUNT = 1,
  parameter int ARCHBITSZ   = 32,
  parameter int PRIOMODE    = 0,
  parameter logic [INTSRCCOUNT-1:0] ENRSTVAL = '1
) (
  input  logic                                             clk_i,
  input  logic                                             rst_i,
  input  logic [1:0]                                       pi1_op_i,
  input  logic [ARCHBITSZ-$clog2(ARCHBITSZ/8)-1:0]         pi1_addr_i,
  input  logic [ARCHBITSZ-1:0]                             pi1_data_i,
  output logic [ARCHBITSZ-1:0]                             pi1_data_o,
  input  logic [ARCHBITSZ/8-1:0]                           pi1_sel_i,
  output logic                                             pi1_rdy_o,
  output logic [ARCHBITSZ-$clog2(ARCHBITSZ/8)-1:0]         pi1_mapsz_o,
  output logic [INTDSTCOUNT-1:0]                           intrqstdst_o,
  input  logic [INTDSTCOUNT-1:0]                           intrdydst_i,
  input  logic [INTDSTCOUNT-1:0]                           intbestdst_i,
  input  logic [INTSRCCOUNT-1:0]                           intrqstsrc_i,
  output logic [INTSRCCOUNT-1:0]                           intrdysrc_o
);

  localparam int ADDRBITSZ = ARCHBITSZ - $clog2(ARCHBITSZ/8);
  localparam int SRCW = (INTSRCCOUNT > 1) ? $clog2(INTSRCCOUNT) : 1;
  localparam int DSTW = (INTDSTCOUNT > 1) ? $clog2(INTDSTCOUNT) : 1;
  localparam logic [SRCW-1:0] SRCLAST = SRCW'(INTSRCCOUNT - 1);
  localparam logic [DSTW-1:0] DSTLAST = DSTW'(INTDSTCOUNT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEEK,
    ST_DELIVER,
    ST_IPI_SEEK
  } state_t;

  state_t                 state_q, state_d;
  logic [SRCW-1:0]        srcindex_q, srcindex_d;
  logic [SRCW-1:0]        srcptr_q, srcptr_d;
  logic [DSTW-1:0]        dstindex_q, dstindex_d;
  logic [DSTW-1:0]        dstindexhi_q, dstindexhi_d;
  logic [DSTW-1:0]        ipitgt_q, ipitgt_d;
  logic                   isipi_q, isipi_d;
  logic [INTSRCCOUNT-1:0] mask_q, mask_d;
  logic [ARCHBITSZ-1:0]   rdata_q, rdata_d;

  logic [INTSRCCOUNT-1:0] pending;
  logic                   bus_rd, bus_wr, cmd, ipi_req, ack_req;
  logic [ARCHBITSZ-1:0]   ipi_full;
  logic [DSTW-1:0]        ipi_tgt;
  logic                   ipi_inrange, ipi_ok;
  logic                   src_found;
  logic [SRCW-1:0]        src_pick;
  logic                   cur_pending, dst_rdy, dst_best, any_best, dst_ok;
  logic [DSTW-1:0]        seek_next, ipi_next;
  logic                   unused_bits;

  assign unused_bits = ^{pi1_sel_i, pi1_addr_i[ADDRBITSZ-1:2]};

  assign pi1_rdy_o   = 1'b1;
  assign pi1_mapsz_o = ADDRBITSZ'(4);
  assign pi1_data_o  = rdata_q;

  assign pending = intrqstsrc_i & mask_q;

  assign bus_rd  = pi1_op_i[1];
  assign bus_wr  = pi1_op_i[0];
  assign cmd     = (pi1_op_i == 2'b11) && (pi1_addr_i[1:0] == 2'd0);
  assign ipi_req = cmd && pi1_data_i[0];
  assign ack_req = cmd && !pi1_data_i[0];

  // Full-width target compare so an out-of-range IPI is rejected rather
  // than aliased onto a valid destination by truncation.
  assign ipi_full    = pi1_data_i >> 1;
  assign ipi_tgt     = ipi_full[DSTW-1:0];
  assign ipi_inrange = ipi_full < ARCHBITSZ'(INTDSTCOUNT);
  assign ipi_ok      = ipi_req && ipi_inrange &&
                       ((state_q == ST_IDLE) || (state_q == ST_SEEK));

  // Source arbitration. Round-robin first searches at/after srcptr, then
  // falls back to the lowest index, which gives the wrap-around order.
  always_comb begin
    src_found = 1'b0;
    src_pick  = '0;
    if (PRIOMODE == 0) begin
      for (int unsigned j = 0; j < INTSRCCOUNT; j++) begin
        if (!src_found && pending[j] && (j >= 32'(srcptr_q))) begin
          src_found = 1'b1;
          src_pick  = SRCW'(j);
        end
      end
    end
    for (int unsigned j = 0; j < INTSRCCOUNT; j++) begin
      if (!src_found && pending[j]) begin
        src_found = 1'b1;
        src_pick  = SRCW'(j);
      end
    end
  end

  // Lookups for the destination under test and the latched source.
  always_comb begin
    dst_rdy     = 1'b0;
    dst_best    = 1'b0;
    any_best    = 1'b0;
    cur_pending = 1'b0;
    for (int unsigned j = 0; j < INTDSTCOUNT; j++) begin
      if (DSTW'(j) == dstindex_q) begin
        dst_rdy  = intrdydst_i[j];
        dst_best = intbestdst_i[j];
      end
      if ((DSTW'(j) <= dstindexhi_q) && intbestdst_i[j]) begin
        any_best = 1'b1;
      end
    end
    for (int unsigned j = 0; j < INTSRCCOUNT; j++) begin
      if (SRCW'(j) == srcindex_q) begin
        cur_pending = pending[j];
      end
    end
  end

  // When a preferred destination exists in range, only it may take the
  // interrupt; otherwise the first ready destination does.
  assign dst_ok    = any_best ? (dst_best && dst_rdy) : dst_rdy;
  assign seek_next = (dstindex_q >= dstindexhi_q) ? '0 : dstindex_q + DSTW'(1);
  // IPI stepping wraps on the full destination range so a software lowering
  // of dstindexhi mid-search cannot strand the target.
  assign ipi_next  = (dstindex_q >= DSTLAST) ? '0 : dstindex_q + DSTW'(1);

  always_comb begin
    state_d      = state_q;
    srcindex_d   = srcindex_q;
    srcptr_d     = srcptr_q;
    dstindex_d   = dstindex_q;
    dstindexhi_d = dstindexhi_q;
    ipitgt_d     = ipitgt_q;
    isipi_d      = isipi_q;
    mask_d       = mask_q;
    rdata_d      = rdata_q;

    if (bus_wr && (pi1_addr_i[1:0] == 2'd1)) begin
      mask_d = pi1_data_i[INTSRCCOUNT-1:0];
    end
    if (bus_wr && (pi1_addr_i[1:0] == 2'd3)) begin
      dstindexhi_d = (pi1_data_i[DSTW-1:0] > DSTLAST) ? DSTLAST : pi1_data_i[DSTW-1:0];
    end

    if (bus_rd) begin
      case (pi1_addr_i[1:0])
        2'd1:    rdata_d = ARCHBITSZ'(mask_q);
        2'd2:    rdata_d = ARCHBITSZ'(pending);
        2'd3:    rdata_d = ARCHBITSZ'(dstindexhi_q);
        default: rdata_d = '0;
      endcase
    end
    if (ack_req) begin
      if ((state_q == ST_DELIVER) && !isipi_q) rdata_d = ARCHBITSZ'(srcindex_q);
      else                                     rdata_d = '1;
    end
    if (ipi_req) begin
      rdata_d = ipi_ok ? ARCHBITSZ'(ipi_tgt) : '1;
    end

    case (state_q)
      ST_IDLE, ST_SEEK: begin
        // An accepted IPI pre-empts both a fresh selection and a running seek.
        if (ipi_ok) begin
          state_d    = ST_IPI_SEEK;
          ipitgt_d   = ipi_tgt;
          dstindex_d = '0;
          if (ipi_tgt > dstindexhi_q) dstindexhi_d = ipi_tgt;
        end else if (state_q == ST_IDLE) begin
          if (src_found) begin
            state_d    = ST_SEEK;
            srcindex_d = src_pick;
            dstindex_d = '0;
          end
        end else if (!cur_pending) begin
          state_d = ST_IDLE;
        end else if (dst_ok) begin
          state_d = ST_DELIVER;
          isipi_d = 1'b0;
        end else begin
          dstindex_d = seek_next;
        end
      end
      ST_IPI_SEEK: begin
        if (dstindex_q == ipitgt_q) begin
          state_d = ST_DELIVER;
          isipi_d = 1'b1;
        end else begin
          dstindex_d = ipi_next;
        end
      end
      ST_DELIVER: begin
        if (ack_req) begin
          state_d = ST_IDLE;
          if (!isipi_q) srcptr_d = (srcindex_q == SRCLAST) ? '0 : srcindex_q + SRCW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      srcindex_q   <= '0;
      srcptr_q     <= '0;
      dstindex_q   <= '0;
      dstindexhi_q <= '0;
      ipitgt_q     <= '0;
      isipi_q      <= 1'b0;
      mask_q       <= ENRSTVAL;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      srcindex_q   <= srcindex_d;
      srcptr_q     <= srcptr_d;
      dstindex_q   <= dstindex_d;
      dstindexhi_q <= dstindexhi_d;
      ipitgt_q     <= ipitgt_d;
      isipi_q      <= isipi_d;
      mask_q       <= mask_d;
      rdata_q      <= rdata_d;
    end
  end

  // Request/ready pins follow the registered state only.
  always_comb begin
    intrqstdst_o = '0;
    intrdysrc_o  = '1;
    if (state_q == ST_DELIVER) begin
      for (int unsigned j = 0; j < INTDSTCOUNT; j++) begin
        if (DSTW'(j) == dstindex_q) intrqstdst_o[j] = 1'b1;
      end
      if (!isipi_q) begin
        for (int unsigned j = 0; j < INTSRCCOUNT; j++) begin
          if (SRCW'(j) == srcindex_q) intrdysrc_o[j] = 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/intctrl2.md
# intctrl2

Parametrised successor interrupt controller on the pi1 peripheral bus. Routes level requests from `INTSRCCOUNT` devices to one of `INTDSTCOUNT` cores, which are the interrupt destinations. It adds a software-visible per-source enable mask, a pending-status register and a programmable destination range. It also adds single-cycle source arbitration, selectable between round-robin and fixed priority. Inter-processor interrupts (IPIs) are issued through the same command/acknowledge word. The block sits beside the other pi1 devices and drives the cores' interrupt request/ready pins.

## Interface
- `INTSRCCOUNT`, 2, number of device interrupt sources; legal range 1..`ARCHBITSZ`.
- `INTDSTCOUNT`, 1, number of destinations (cores); legal range 1..2^(`ARCHBITSZ`-1).
- `ARCHBITSZ`, 32, data width; 32 or 64.
- `PRIOMODE`, 0, source arbitration: 0 = round-robin, 1 = fixed priority (lowest index wins).
- `ENRSTVAL`, all-ones, reset value of the enable mask (`INTSRCCOUNT` bits).
- Widths: `SRCW`=clog2(`INTSRCCOUNT`), `DSTW`=clog2(`INTDSTCOUNT`), both with a minimum of 1. `ADDRBITSZ`=`ARCHBITSZ`-clog2(`ARCHBITSZ`/8).
- `clk_i`  in  1  single clock; all state updates on its rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `pi1_op_i`  in  2  00 = no-op, 01 = write, 10 = read, 11 = read-write.
- `pi1_addr_i`  in  `ADDRBITSZ`  word offset; only bits [1:0] are decoded.
- `pi1_data_i`  in  `ARCHBITSZ`  write data.
- `pi1_data_o`  out  `ARCHBITSZ`  registered read data.
- `pi1_sel_i`  in  `ARCHBITSZ`/8  byte selects; ignored.
- `pi1_rdy_o`  out  1  constant 1.
- `pi1_mapsz_o`  out  `ADDRBITSZ`  constant 4 (words).
- `intrqstdst_o`  out  `INTDSTCOUNT`  interrupt request to each destination.
- `intrdydst_i`  in  `INTDSTCOUNT`  destination can accept an interrupt.
- `intbestdst_i`  in  `INTDSTCOUNT`  destination is the preferred target.
- `intrqstsrc_i`  in  `INTSRCCOUNT`  level request from each source.
- `intrdysrc_o`  out  `INTSRCCOUNT`  low while that source's request is being delivered.

## Operation
- Register map (word offset):
  - 0 (read-write only): command/acknowledge.
    - `data_i[0]`=1: IPI to destination `data_i[DSTW:1]`.
    - `data_i[0]`=0: acknowledge the delivered interrupt.
  - 1: enable mask. Write sets the mask to `data_i[INTSRCCOUNT-1:0]`; read returns the mask, zero-extended.
  - 2: read-only pending status = `intrqstsrc_i` & mask. Writes are ignored.
  - 3: `dstindexhi`. Write stores min(`data_i[DSTW-1:0]`, `INTDSTCOUNT`-1); read returns it.
- Eligible destinations are indices 0..`dstindexhi`.
- An IPI whose target exceeds `dstindexhi` raises `dstindexhi` to that target.
- States:
  - IDLE: pick a source.
    - Eligible sources = pending status.
    - `PRIOMODE`=0: choose the first eligible source at or after `srcptr`, wrapping.
    - `PRIOMODE`=1: choose the lowest eligible index.
    - If a source is found: latch `srcindex`, clear `dstindex`, go to SEEK.
  - SEEK: test one destination per cycle.
    - If any `intbestdst_i` is set within range, deliver only to a best destination.
    - Otherwise deliver to the first destination with `intrdydst_i` set.
    - If the tested destination does not qualify, advance `dstindex`, wrapping from `dstindexhi` to 0.
    - If the chosen source drops or becomes masked, return to IDLE.
  - DELIVER: assert `intrqstdst_o[dstindex]`. For a device interrupt, also drive `intrdysrc_o[srcindex]` low.
    - An acknowledge returns `srcindex`, or all-ones if the delivery is an IPI.
    - On acknowledge: set `srcptr` = `srcindex`+1 (wrapping), return to IDLE.
  - IPI_SEEK: step `dstindex` until it equals the IPI target, then go to DELIVER with the IPI flag set.
- IPI command handling:
  - Accepted only in IDLE or SEEK; accepting it aborts any SEEK in progress. Result = target index.
  - Rejected with result all-ones if the target is ≥ `INTDSTCOUNT` or the state is DELIVER or IPI_SEEK. No state change.
- An acknowledge outside DELIVER returns all-ones and has no effect.
- An op at an unused offset returns 0.
- Masking a source during DELIVER does not cancel the delivery.

## Timing
- Reset values:
  - `pi1_data_o`=0, `intrqstdst_o`=0, `intrdysrc_o`=all-ones.
  - mask=`ENRSTVAL`, `dstindexhi`=0, `srcptr`=0, `dstindex`=0, state IDLE.
- Reset mid-delivery drops `intrqstdst_o` on the next edge.
- Bus ops are accepted every cycle. `pi1_data_o` is valid the cycle after the op and holds until the next read or read-write.
- Interrupt path latency:
  - IDLE→SEEK: 1 cycle.
  - SEEK: 1 cycle per destination tested.
  - Source asserted with destination 0 ready: `intrqstdst_o[0]` rises 2 cycles after the source.
- Ack edge: `intrqstdst_o` and the source's `intrdysrc_o` low deassert on the same edge. The next selection happens the following cycle.
- Mask write takes effect for arbitration on the next cycle.
- An IPI and a source becoming eligible in the same cycle: the IPI wins.

## Test plan
- Reset; source 0 high; `intrdydst_i`=1 → `intrqstdst_o`=1 two cycles later and `intrdysrc_o[0]`=0. Ack at offset 0 → `pi1_data_o`=0, then `intrqstdst_o`=0.
- `PRIOMODE`=0, 4 sources all high, continuous ack → delivered order 0,1,2,3,0. `PRIOMODE`=1 with the same stimulus → order 0,0,0.
- Write mask=0b1010; sources 0–3 high → pending status reads 0xA; only sources 1 and 3 are delivered.
- `INTDSTCOUNT`=4; IPI to dst 2 → `pi1_data_o`=2, `dstindexhi`=2, `intrqstdst_o`=0b0100; ack → all-ones.
- IPI to dst 7 with `INTDSTCOUNT`=4 → all-ones, no request. IPI during DELIVER → all-ones. Ack in IDLE → all-ones.
- `dstindexhi`=3; `intrdydst_i`=0b1111, `intbestdst_i`=0b1000 → request goes to dst 3. Assert `rst_i` during DELIVER → all outputs at reset values on the next cycle.
